// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the memory arbiter
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } state_e;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_DBG  = 1'b1
  } port_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - core/debug requester ports and memory port bundle
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
) ();

  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [31:0]       core_wdata;
  logic [2:0]        core_funct3;
  logic              core_gnt;
  logic              core_rvalid;
  logic [31:0]       core_rdata;
  logic              core_err;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [31:0]       dbg_wdata;
  logic [2:0]        dbg_funct3;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [31:0]       dbg_rdata;
  logic              dbg_err;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, core_funct3,
    output core_gnt, core_rvalid, core_rdata, core_err,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_funct3,
    output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
    output mem_en, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, core_funct3,
    input  core_gnt, core_rvalid, core_rdata, core_err,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_funct3,
    input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
    input  mem_en, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane strobes, store replication, load extraction/extension
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);

  logic [31:0] w_lane;
  logic        w_unsigned;

  assign w_lane     = i_rdata >> {i_addr_lo, 3'b000};
  assign w_unsigned = i_funct3[2];

  always_comb begin
    o_wstrb      = 4'b1111;
    o_wdata      = i_wdata;
    o_rdata      = w_lane;
    o_misaligned = 1'b0;
    case (i_funct3[1:0])
      SZ_BYTE: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = w_unsigned ? {24'h0, w_lane[7:0]} : {{24{w_lane[7]}}, w_lane[7:0]};
      end
      SZ_HALF: begin
        o_wstrb      = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata      = {2{i_wdata[15:0]}};
        o_rdata      = w_unsigned ? {16'h0, w_lane[15:0]} : {{16{w_lane[15]}}, w_lane[15:0]};
        o_misaligned = i_addr_lo[0];
      end
      // SZ_WORD and the reserved encoding both behave as a full word
      default: begin
        o_misaligned = |i_addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin core/debug arbiter onto a single synchronous memory port
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  state_e            r_state;
  state_e            w_next;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [2:0]        r_funct3;
  port_e             r_port;
  port_e             r_last;

  logic              w_any_req;
  port_e             w_win;
  logic [3:0]        w_wstrb;
  logic [31:0]       w_wdata;
  logic [31:0]       w_rdata;
  logic              w_mis;
  logic [31:0]       w_resp_data;

  assign w_any_req = bus.core_req | bus.dbg_req;
  // Core wins if alone, or on a tie when debug was served last
  assign w_win = (bus.core_req && (!bus.dbg_req || r_last == PORT_DBG)) ? PORT_CORE : PORT_DBG;

  mem_lane_align u_align (
    .i_addr_lo    (r_addr[1:0]),
    .i_funct3     (r_funct3),
    .i_wdata      (r_wdata),
    .i_rdata      (bus.mem_rdata),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .o_rdata      (w_rdata),
    .o_misaligned (w_mis)
  );

  assign w_resp_data = (w_mis || r_we) ? 32'h0 : w_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_funct3 <= 3'b000;
      r_port   <= PORT_CORE;
      r_last   <= PORT_DBG;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_any_req) begin
        r_port <= w_win;
        r_last <= w_win;
        if (w_win == PORT_CORE) begin
          r_we     <= bus.core_we;
          r_addr   <= bus.core_addr;
          r_wdata  <= bus.core_wdata;
          r_funct3 <= bus.core_funct3;
        end else begin
          r_we     <= bus.dbg_we;
          r_addr   <= bus.dbg_addr;
          r_wdata  <= bus.dbg_wdata;
          r_funct3 <= bus.dbg_funct3;
        end
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    bus.core_gnt    = 1'b0;
    bus.core_rvalid = 1'b0;
    bus.core_rdata  = 32'h0;
    bus.core_err    = 1'b0;
    bus.dbg_gnt     = 1'b0;
    bus.dbg_rvalid  = 1'b0;
    bus.dbg_rdata   = 32'h0;
    bus.dbg_err     = 1'b0;
    bus.mem_en      = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wstrb   = 4'b0000;
    bus.mem_wdata   = 32'h0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) w_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_next        = ST_RESP;
        bus.core_gnt  = (r_port == PORT_CORE);
        bus.dbg_gnt   = (r_port == PORT_DBG);
        bus.mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
        bus.mem_wdata = w_wdata;
        // A misaligned access is granted but never reaches the memory
        if (!w_mis) begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = r_we;
          bus.mem_wstrb = r_we ? w_wstrb : 4'b0000;
        end
      end
      ST_RESP: begin
        w_next = ST_IDLE;
        if (r_port == PORT_CORE) begin
          bus.core_rvalid = 1'b1;
          bus.core_rdata  = w_resp_data;
          bus.core_err    = w_mis;
        end else begin
          bus.dbg_rvalid  = 1'b1;
          bus.dbg_rdata   = w_resp_data;
          bus.dbg_err     = w_mis;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.core_req    = 1'b0;
    bus.core_we     = 1'b0;
    bus.core_addr   = 32'h0;
    bus.core_wdata  = 32'h0;
    bus.core_funct3 = 3'b000;
    bus.dbg_req     = 1'b0;
    bus.dbg_we      = 1'b0;
    bus.dbg_addr    = 32'h0;
    bus.dbg_wdata   = 32'h0;
    bus.dbg_funct3  = 3'b000;
    bus.mem_rdata   = 32'h0;
  endtask

  task automatic drive_core(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [2:0] f3);
    bus.core_req    = 1'b1;
    bus.core_we     = we;
    bus.core_addr   = addr;
    bus.core_wdata  = wdata;
    bus.core_funct3 = f3;
  endtask

  task automatic drive_dbg(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3);
    bus.dbg_req    = 1'b1;
    bus.dbg_we     = we;
    bus.dbg_addr   = addr;
    bus.dbg_wdata  = wdata;
    bus.dbg_funct3 = f3;
  endtask

  task automatic test_reset();
    logic [7:0] flags;
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    flags = {bus.core_gnt, bus.core_rvalid, bus.core_err, bus.dbg_gnt, bus.dbg_rvalid,
             bus.dbg_err, bus.mem_en, bus.mem_we};
    checks++;
    if (flags !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000000", flags);
    end
    checks++;
    if ({bus.core_rdata, bus.dbg_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== 132'h0) begin
      errors++;
      $display("FAIL reset_buses: core_rdata %h dbg_rdata %h mem_addr %h mem_wdata %h wstrb %b expected all 0",
               bus.core_rdata, bus.dbg_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.core_gnt, bus.dbg_gnt, bus.mem_en} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release_idle: got %b expected 000", {bus.core_gnt, bus.dbg_gnt, bus.mem_en});
    end
  endtask

  task automatic test_load_word();
    drive_core(1'b0, 32'h10, 32'h0, 3'b010);
    bus.mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({bus.core_gnt, bus.dbg_gnt, bus.mem_en, bus.mem_we, bus.mem_wstrb} !== 8'b1010_0000) begin
      errors++;
      $display("FAIL lw_issue: gnt/dgnt/en/we/wstrb got %b expected 10100000",
               {bus.core_gnt, bus.dbg_gnt, bus.mem_en, bus.mem_we, bus.mem_wstrb});
    end
    checks++;
    if (bus.mem_addr !== 32'h10) begin
      errors++;
      $display("FAIL lw_addr: got %h expected 00000010", bus.mem_addr);
    end
    bus.core_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.core_rvalid, bus.core_err, bus.dbg_rvalid, bus.mem_en} !== 4'b1000) begin
      errors++;
      $display("FAIL lw_resp_flags: rv/err/drv/en got %b expected 1000",
               {bus.core_rvalid, bus.core_err, bus.dbg_rvalid, bus.mem_en});
    end
    checks++;
    if (bus.core_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lw_rdata: got %h expected deadbeef", bus.core_rdata);
    end
    @(negedge clk);
    checks++;
    if ({bus.core_rvalid, bus.core_gnt} !== 2'b00) begin
      errors++;
      $display("FAIL lw_pulse_end: rv/gnt got %b expected 00", {bus.core_rvalid, bus.core_gnt});
    end
  endtask

  task automatic test_store_byte();
    drive_core(1'b1, 32'h13, 32'h0000_00A5, 3'b000);
    bus.mem_rdata = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if ({bus.core_gnt, bus.mem_en, bus.mem_we, bus.mem_wstrb} !== 7'b111_1000) begin
      errors++;
      $display("FAIL sb_issue: gnt/en/we/wstrb got %b expected 1111000",
               {bus.core_gnt, bus.mem_en, bus.mem_we, bus.mem_wstrb});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata} !== {32'h10, 32'hA5A5A5A5}) begin
      errors++;
      $display("FAIL sb_addr_data: addr %h wdata %h expected 00000010 a5a5a5a5", bus.mem_addr, bus.mem_wdata);
    end
    bus.core_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.core_rvalid, bus.core_err, bus.core_rdata} !== {2'b10, 32'h0}) begin
      errors++;
      $display("FAIL sb_resp: rv %b err %b rdata %h expected 1 0 00000000",
               bus.core_rvalid, bus.core_err, bus.core_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_store_half();
    drive_dbg(1'b1, 32'h06, 32'hFFFF_1234, 3'b001);
    @(negedge clk);
    checks++;
    if ({bus.dbg_gnt, bus.core_gnt, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata}
        !== {2'b10, 4'b1100, 32'h04, 32'h12341234}) begin
      errors++;
      $display("FAIL sh_issue: dgnt %b cgnt %b wstrb %b addr %h wdata %h expected 1 0 1100 00000004 12341234",
               bus.dbg_gnt, bus.core_gnt, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata);
    end
    bus.dbg_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3s   [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] addrs [4] = '{32'h01, 32'h01, 32'h02, 32'h02};
    logic [31:0] mems  [4] = '{32'h0000_8000, 32'h0000_8000, 32'h8001_0000, 32'h8001_0000};
    logic [31:0] exps  [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001};
    for (int i = 0; i < 4; i++) begin
      drive_dbg(1'b0, addrs[i], 32'h0, f3s[i]);
      bus.mem_rdata = mems[i];
      @(negedge clk);
      bus.dbg_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.dbg_rvalid, bus.dbg_err, bus.core_rvalid, bus.dbg_rdata} !== {3'b100, exps[i]}) begin
        errors++;
        $display("FAIL load_ext[%0d]: rv %b err %b core_rv %b rdata %h expected 1 0 0 %h",
                 i, bus.dbg_rvalid, bus.dbg_err, bus.core_rvalid, bus.dbg_rdata, exps[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_misaligned();
    logic        wes   [2] = '{1'b0, 1'b1};
    logic [31:0] addrs [2] = '{32'h03, 32'h02};
    logic [2:0]  f3s   [2] = '{3'b001, 3'b010};
    for (int i = 0; i < 2; i++) begin
      drive_core(wes[i], addrs[i], 32'hCAFE_F00D, f3s[i]);
      bus.mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      checks++;
      if ({bus.core_gnt, bus.mem_en, bus.mem_we, bus.mem_wstrb} !== 7'b100_0000) begin
        errors++;
        $display("FAIL misalign_issue[%0d]: gnt/en/we/wstrb got %b expected 1000000",
                 i, {bus.core_gnt, bus.mem_en, bus.mem_we, bus.mem_wstrb});
      end
      bus.core_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.core_rvalid, bus.core_err, bus.mem_en, bus.core_rdata} !== {3'b110, 32'h0}) begin
        errors++;
        $display("FAIL misalign_resp[%0d]: rv %b err %b en %b rdata %h expected 1 1 0 00000000",
                 i, bus.core_rvalid, bus.core_err, bus.mem_en, bus.core_rdata);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] got;
    logic [3:0] exp;
    logic       g, r, c;
    reset = 1'b1;
    clear_inputs();
    drive_core(1'b0, 32'h20, 32'h0, 3'b010);
    drive_dbg(1'b0, 32'h24, 32'h0, 3'b010);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      g   = (k % 3 == 0);
      r   = (k % 3 == 1);
      c   = ((k / 3) % 2 == 0);
      exp = {g & c, g & ~c, r & c, r & ~c};
      got = {bus.core_gnt, bus.dbg_gnt, bus.core_rvalid, bus.dbg_rvalid};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rr_cycle[%0d]: cgnt/dgnt/crv/drv got %b expected %b", k, got, exp);
      end
    end
    bus.core_req = 1'b0;
    bus.dbg_req  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ignore_busy();
    drive_core(1'b0, 32'h40, 32'h0, 3'b010);
    @(negedge clk);
    bus.core_req = 1'b0;
    drive_dbg(1'b0, 32'h44, 32'h0, 3'b010);
    @(negedge clk);
    bus.dbg_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.dbg_gnt, bus.dbg_rvalid, bus.mem_en} !== 3'b000) begin
        errors++;
        $display("FAIL ignore_busy[%0d]: dgnt/drv/en got %b expected 000",
                 k, {bus.dbg_gnt, bus.dbg_rvalid, bus.mem_en});
      end
    end
  endtask

  task automatic test_reset_abort();
    drive_core(1'b0, 32'h30, 32'h0, 3'b010);
    bus.mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    checks++;
    if ({bus.core_gnt, bus.mem_en} !== 2'b11) begin
      errors++;
      $display("FAIL abort_issue: gnt/en got %b expected 11", {bus.core_gnt, bus.mem_en});
    end
    reset        = 1'b1;
    bus.core_req = 1'b0;
    #1;
    checks++;
    if ({bus.core_gnt, bus.core_rvalid, bus.mem_en, bus.mem_addr, bus.core_rdata} !== 67'h0) begin
      errors++;
      $display("FAIL abort_async: gnt %b rv %b en %b addr %h rdata %h expected all 0",
               bus.core_gnt, bus.core_rvalid, bus.mem_en, bus.mem_addr, bus.core_rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.core_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_rvalid: got %b expected 0", bus.core_rvalid);
    end
    @(negedge clk);
    checks++;
    if ({bus.core_rvalid, bus.core_gnt, bus.mem_en} !== 3'b000) begin
      errors++;
      $display("FAIL abort_idle: rv/gnt/en got %b expected 000", {bus.core_rvalid, bus.core_gnt, bus.mem_en});
    end
    drive_core(1'b0, 32'h30, 32'h0, 3'b010);
    @(negedge clk);
    checks++;
    if (bus.core_gnt !== 1'b1) begin
      errors++;
      $display("FAIL abort_rerequest_gnt: got %b expected 1", bus.core_gnt);
    end
    bus.core_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.core_rvalid, bus.core_rdata} !== {1'b1, 32'h5555AAAA}) begin
      errors++;
      $display("FAIL abort_rerequest_resp: rv %b rdata %h expected 1 5555aaaa", bus.core_rvalid, bus.core_rdata);
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load_word();
    test_store_byte();
    test_store_half();
    test_load_extend();
    test_misaligned();
    test_round_robin();
    test_ignore_busy();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, byte-address width of all address ports.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  reset, asynchronous, active-high.
REQ-004 core_req  in  1  core requests an access; held with payload until core_gnt.
REQ-005 core_we  in  1  1 = store, 0 = load.
REQ-006 core_addr  in  ADDR_W  byte address.
REQ-007 core_wdata  in  32  store data, right-aligned.
REQ-008 core_funct3  in  3  [1:0] size (00 byte, 01 half, 10 word, 11 treated as word); [2] unsigned load.
REQ-009 core_gnt  out  1  one-cycle pulse: request accepted.
REQ-010 core_rvalid  out  1  one-cycle pulse: response (load data or store ack).
REQ-011 core_rdata  out  32  extended load data; 0 for stores and errors.
REQ-012 core_err  out  1  misaligned access flag, valid with core_rvalid.
REQ-013 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_funct3, dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err: debug/loader port, same directions, widths and meaning as core_*.
REQ-014 mem_en  out  1  memory access strobe.
REQ-015 mem_we  out  1  memory write enable.
REQ-016 mem_addr  out  ADDR_W  word-aligned address ([1:0] = 00).
REQ-017 mem_wstrb  out  4  byte-lane write strobes.
REQ-018 mem_wdata  out  32  lane-replicated store data.
REQ-019 mem_rdata  in  32  synchronous-read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-020 FSM states IDLE, ISSUE, RESP; IDLE->ISSUE when any req is high; ISSUE->RESP always; RESP->IDLE always.
REQ-021 In IDLE with a request, the winner's we/addr/wdata/funct3 and port id SHALL be latched into internal registers.
REQ-022 Arbitration: single request wins; with both requests, the port not served last wins (round-robin); last-served register updates on every latch.
REQ-023 Latency: req sampled in IDLE at cycle N -> gnt pulse and mem_en in cycle N+1 (ISSUE) -> rvalid pulse in N+2 (RESP); throughput one access per 3 cycles.
REQ-024 The losing requester's gnt SHALL stay 0; its request is served in the next IDLE cycle if still held.
REQ-025 mem_* outputs SHALL be driven only in ISSUE from latched registers; all other states mem_en=0, mem_we=0, mem_wstrb=0.
REQ-026 Store strobes: byte -> 4'b0001 << addr[1:0]; half -> 0011 (addr[1]=0) or 1100 (addr[1]=1); word -> 1111.
REQ-027 Store data: byte replicated to 4 lanes, half replicated to 2 lanes, word unchanged.
REQ-028 Load data: selected lane = mem_rdata >> 8*addr[1:0], byte/half sign-extended when funct3[2]=0, else zero-extended.
REQ-029 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): mem_en stays 0 in ISSUE, gnt still pulses, RESP gives rvalid=1, err=1, rdata=0.
REQ-030 rvalid/rdata/err SHALL be driven only to the latched port; the other port's response outputs are 0.
REQ-031 Requests arriving in ISSUE or RESP SHALL be ignored until IDLE.

Reset
REQ-032 Reset SHALL force IDLE, all outputs 0, last-served = dbg (core wins first tie), latched payload cleared.
REQ-033 Reset asserted in ISSUE or RESP SHALL abort the transaction with no rvalid pulse; the requester re-requests.

Structure
REQ-034 Package mem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum and the port-id enum.
REQ-035 Combinational sub-module mem_lane_align SHALL implement REQ-026..REQ-029 (strobe, replication, extraction, extension, misalign detect); mem_arbiter holds FSM and arbitration.

Verification
REQ-036 Core load word addr 0x10, mem_rdata 0xDEADBEEF -> gnt cycle N+1 with mem_addr 0x10, wstrb 0000; rvalid N+2, rdata 0xDEADBEEF, err 0.
REQ-037 Core store byte 0xA5 at 0x13 -> mem_addr 0x10, wstrb 1000, wdata 0xA5A5A5A5, rvalid N+2 with rdata 0.
REQ-038 Load byte at 0x01 with mem_rdata 0x00008000: funct3=000 -> rdata 0xFFFFFF80; funct3=100 -> 0x00000080.
REQ-039 Both ports request continuously from reset -> grants alternate core, dbg, core, dbg at 3-cycle spacing.
REQ-040 Half load at 0x03 -> mem_en never asserts, rvalid with err=1, rdata 0.
REQ-041 Reset pulsed during ISSUE -> no rvalid, FSM in IDLE next cycle, all outputs 0.
